// File: rtl/nios_cpu_debug_ocimem.sv
// ---------------------------------------------------------------------------
// nios_cpu_debug_ocimem
//
// Debug on-chip memory block of the CPU debug core. It holds a 2**ADDR_W x 32
// debug RAM and the monitor control flags. Two agents share them: the JTAG
// host, through the decoded payload and action strobes of the debug-slave
// wrapper, and the CPU, through its debug Avalon slave. Debug read data is
// returned in MonDReg, and the monitor flags feed back to the wrapper.
//
// Ports
//   clk, reset               system clock, asynchronous active-high reset
//   jdo[37:0]                decoded JTAG payload, stable while a strobe is high
//   take_action_ocimem_a     debug command: flag clear/set and address load
//   take_action_ocimem_b     debug write RAM[MonAReg] and post-increment
//   take_no_action_ocimem_a  debug read RAM[MonAReg] and post-increment
//   cpu_address[ADDR_W:0]    MSB=1 selects the control register, else a RAM word
//   cpu_read, cpu_write      Avalon read / write requests
//   cpu_writedata[31:0]      Avalon write data
//   cpu_readdata[31:0]       Avalon read data
//   cpu_waitrequest          Avalon wait
//   MonDReg[31:0]            debug read data returned to the wrapper
//   monitor_ready/error      sticky flags, set by the CPU, cleared by JTAG
//   monitor_go               sticky flag, set by JTAG, cleared by the CPU
//   dbg_overrun              sticky: a debug strobe was dropped
// ---------------------------------------------------------------------------
module nios_cpu_debug_ocimem #(
   parameter int ADDR_W        = 8,
   parameter int RAM_INIT_ZERO = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   input  logic [ADDR_W:0]   cpu_address,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [31:0]       cpu_writedata,
   output logic [31:0]       cpu_readdata,
   output logic              cpu_waitrequest,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error,
   output logic              monitor_go,
   output logic              dbg_overrun
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [31:0] RAM_INIT_WORD =
      (RAM_INIT_ZERO != 0) ? 32'h0000_0000 : 32'hxxxx_xxxx;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DBG_RD  = 2'd1,
      ST_DBG_CAP = 2'd2,
      ST_CPU_RD  = 2'd3
   } state_t;

   state_t              state_r;
   state_t              state_s;

   // The RAM itself has no reset; the declaration initialiser only sets the
   // power-up contents.
   logic [31:0]         ram_r [DEPTH] = '{default: RAM_INIT_WORD};
   logic [31:0]         ram_q_r;
   logic [ADDR_W-1:0]   mon_a_r;
   logic [ADDR_W-1:0]   dbg_rd_addr_r;

   logic                any_strobe_s;
   logic                multi_strobe_s;
   logic                idle_s;
   logic                acc_a_s;
   logic                acc_b_s;
   logic                acc_rd_s;
   logic                overrun_set_s;
   logic                ctrl_sel_s;
   logic                cpu_ram_rd_s;
   logic                cpu_ram_wr_s;
   logic                cpu_ctrl_wr_s;
   logic                cpu_slot_s;
   logic                cpu_rd_launch_s;
   logic                cpu_wr_go_s;
   logic                ram_rd_en_s;
   logic [ADDR_W-1:0]   ram_rd_addr_s;
   logic                unused_jdo_s;

   assign unused_jdo_s = ^{jdo[37:35], jdo[2:0]};

   // A debug strobe is only acted on when the engine is idle. When several
   // strobes are high together, only the highest-priority one is used.
   assign any_strobe_s   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
   assign multi_strobe_s = (take_action_ocimem_a & take_action_ocimem_b)
                         | (take_action_ocimem_a & take_no_action_ocimem_a)
                         | (take_action_ocimem_b & take_no_action_ocimem_a);
   assign idle_s         = (state_r == ST_IDLE);
   assign acc_a_s        = idle_s & take_action_ocimem_a;
   assign acc_b_s        = idle_s & ~take_action_ocimem_a & take_action_ocimem_b;
   assign acc_rd_s       = idle_s & ~take_action_ocimem_a & ~take_action_ocimem_b
                         & take_no_action_ocimem_a;
   assign overrun_set_s  = any_strobe_s & (~idle_s | multi_strobe_s);

   // CPU side decode. A RAM access only gets an idle cycle that carries no
   // debug traffic. The one exception is DBG_CAP: the RAM read port is free
   // there, so a waiting CPU read is launched straight away.
   assign ctrl_sel_s      = cpu_address[ADDR_W];
   assign cpu_ram_rd_s    = cpu_read & ~ctrl_sel_s;
   assign cpu_ram_wr_s    = cpu_write & ~ctrl_sel_s;
   assign cpu_ctrl_wr_s   = cpu_write & ctrl_sel_s;
   assign cpu_slot_s      = idle_s & ~any_strobe_s;
   assign cpu_rd_launch_s = cpu_ram_rd_s & (cpu_slot_s | (state_r == ST_DBG_CAP));
   assign cpu_wr_go_s     = cpu_ram_wr_s & cpu_slot_s;

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (acc_rd_s) begin
               state_s = ST_DBG_RD;
            end else if (cpu_rd_launch_s) begin
               state_s = ST_CPU_RD;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_DBG_RD:  state_s = ST_DBG_CAP;
         ST_DBG_CAP: begin
            if (cpu_rd_launch_s) begin
               state_s = ST_CPU_RD;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_CPU_RD:  state_s = ST_IDLE;
         default:    state_s = ST_IDLE;
      endcase
   end

   // RAM read-port address select and Avalon response
   always_comb begin
      ram_rd_en_s     = 1'b0;
      ram_rd_addr_s   = cpu_address[ADDR_W-1:0];
      cpu_waitrequest = 1'b0;
      cpu_readdata    = ram_q_r;
      if (state_r == ST_DBG_RD) begin
         ram_rd_en_s   = 1'b1;
         ram_rd_addr_s = dbg_rd_addr_r;
      end else begin
         ram_rd_en_s   = cpu_rd_launch_s;
         ram_rd_addr_s = cpu_address[ADDR_W-1:0];
      end
      if (cpu_ram_rd_s) begin
         // Data is only ready in the cycle after the RAM access was launched.
         cpu_waitrequest = (state_r != ST_CPU_RD);
      end else if (cpu_ram_wr_s) begin
         cpu_waitrequest = ~cpu_slot_s;
      end else begin
         cpu_waitrequest = 1'b0;
      end
      if (cpu_read && ctrl_sel_s) begin
         cpu_readdata = {29'h0000_0000, monitor_go, monitor_error, monitor_ready};
      end else begin
         cpu_readdata = ram_q_r;
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // RAM write port. Writes are blocked while reset is held, so reset leaves
   // the contents unchanged.
   always_ff @(posedge clk) begin
      if (!reset && acc_b_s) begin
         ram_r[mon_a_r] <= jdo[34:3];
      end else if (!reset && cpu_wr_go_s) begin
         ram_r[cpu_address[ADDR_W-1:0]] <= cpu_writedata;
      end
   end

   // RAM read-data register, shared by debug reads and CPU reads
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ram_q_r <= 32'h0000_0000;
      end else if (ram_rd_en_s) begin
         ram_q_r <= ram_r[ram_rd_addr_s];
      end
   end

   // Debug address pointer (wraps modulo DEPTH) and latched read address
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mon_a_r       <= {ADDR_W{1'b0}};
         dbg_rd_addr_r <= {ADDR_W{1'b0}};
      end else begin
         if (acc_a_s) begin
            if (jdo[17]) begin
               mon_a_r <= jdo[26 +: ADDR_W];
            end
         end else if (acc_b_s || acc_rd_s) begin
            mon_a_r <= mon_a_r + ONE_A;
         end
         if (acc_rd_s) begin
            dbg_rd_addr_r <= mon_a_r;
         end
      end
   end

   // Debug read data capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         MonDReg <= 32'h0000_0000;
      end else if (state_r == ST_DBG_CAP) begin
         MonDReg <= ram_q_r;
      end
   end

   // Monitor flags: a JTAG clear beats a CPU set, and a CPU clear beats a
   // JTAG set
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         monitor_ready <= 1'b0;
         monitor_error <= 1'b0;
         monitor_go    <= 1'b0;
      end else begin
         if (acc_a_s && jdo[34]) begin
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
         end else begin
            if (cpu_ctrl_wr_s && cpu_writedata[0]) begin
               monitor_ready <= 1'b1;
            end
            if (cpu_ctrl_wr_s && cpu_writedata[1]) begin
               monitor_error <= 1'b1;
            end
         end
         if (cpu_ctrl_wr_s && cpu_writedata[2]) begin
            monitor_go <= 1'b0;
         end else if (acc_a_s && jdo[25]) begin
            monitor_go <= 1'b1;
         end
      end
   end

   // Overrun flag. A dropped strobe is reported even when an accepted
   // ocimem_a would otherwise clear the flag in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dbg_overrun <= 1'b0;
      end else if (overrun_set_s) begin
         dbg_overrun <= 1'b1;
      end else if (acc_a_s) begin
         dbg_overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_nios_cpu_debug_ocimem.sv
module tb_nios_cpu_debug_ocimem;

   logic        clk = 1'b0;
   logic        reset;
   logic [37:0] jdo;
   logic        take_action_ocimem_a;
   logic        take_action_ocimem_b;
   logic        take_no_action_ocimem_a;
   logic [8:0]  cpu_address;
   logic        cpu_read;
   logic        cpu_write;
   logic [31:0] cpu_writedata;
   logic [31:0] cpu_readdata;
   logic        cpu_waitrequest;
   logic [31:0] MonDReg;
   logic        monitor_ready;
   logic        monitor_error;
   logic        monitor_go;
   logic        dbg_overrun;

   int tests = 0;
   int fails = 0;

   // reference model state
   logic [31:0] m_mem [256];
   int          m_ptr;
   logic        m_ready, m_error, m_go, m_ovr;
   logic [31:0] m_mondreg;

   nios_cpu_debug_ocimem #(.ADDR_W(8), .RAM_INIT_ZERO(1)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .jdo                     (jdo),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .cpu_address             (cpu_address),
      .cpu_read                (cpu_read),
      .cpu_write               (cpu_write),
      .cpu_writedata           (cpu_writedata),
      .cpu_readdata            (cpu_readdata),
      .cpu_waitrequest         (cpu_waitrequest),
      .MonDReg                 (MonDReg),
      .monitor_ready           (monitor_ready),
      .monitor_error           (monitor_error),
      .monitor_go              (monitor_go),
      .dbg_overrun             (dbg_overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_flags(input string tag);
      chk({tag, "_ready"}, {31'd0, monitor_ready}, {31'd0, m_ready});
      chk({tag, "_error"}, {31'd0, monitor_error}, {31'd0, m_error});
      chk({tag, "_go"}, {31'd0, monitor_go}, {31'd0, m_go});
      chk({tag, "_ovr"}, {31'd0, dbg_overrun}, {31'd0, m_ovr});
   endtask

   task automatic dbg_a(input bit clr, input bit go, input bit ld, input int addr);
      logic [31:0] a32;
      a32 = addr;
      jdo = '0;
      jdo[34] = clr;
      jdo[25] = go;
      jdo[17] = ld;
      jdo[33:26] = a32[7:0];
      take_action_ocimem_a = 1'b1;
      tick();
      take_action_ocimem_a = 1'b0;
      jdo = '0;
      if (clr) begin
         m_ready = 1'b0;
         m_error = 1'b0;
      end
      if (go) m_go = 1'b1;
      if (ld) m_ptr = addr % 256;
      m_ovr = 1'b0;
   endtask

   task automatic dbg_b(input logic [31:0] d);
      jdo = '0;
      jdo[34:3] = d;
      take_action_ocimem_b = 1'b1;
      tick();
      take_action_ocimem_b = 1'b0;
      jdo = '0;
      m_mem[m_ptr] = d;
      m_ptr = (m_ptr + 1) % 256;
   endtask

   // debug read: data must appear after the second edge following the strobe edge
   task automatic dbg_rd(input string tag);
      logic [31:0] exp;
      exp = m_mem[m_ptr];
      jdo = '0;
      take_no_action_ocimem_a = 1'b1;
      tick();
      take_no_action_ocimem_a = 1'b0;
      m_ptr = (m_ptr + 1) % 256;
      tick();
      chk({tag, "_early"}, MonDReg, m_mondreg);
      tick();
      chk(tag, MonDReg, exp);
      m_mondreg = exp;
   endtask

   task automatic cpu_wr(input logic [8:0] a, input logic [31:0] d, output int waits);
      bit done;
      done = 1'b0;
      waits = 0;
      cpu_address = a;
      cpu_writedata = d;
      cpu_write = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         #1;
         if (!cpu_waitrequest) done = 1'b1;
         else waits++;
         tick();
      end
      cpu_write = 1'b0;
      chk("cpu_wr_done", {31'd0, done}, 32'd1);
      if (a[8]) begin
         if (d[0]) m_ready = 1'b1;
         if (d[1]) m_error = 1'b1;
         if (d[2]) m_go = 1'b0;
      end else begin
         m_mem[a[7:0]] = d;
      end
   endtask

   task automatic cpu_rd(input logic [8:0] a, output logic [31:0] d, output int waits);
      bit done;
      done = 1'b0;
      waits = 0;
      d = '0;
      cpu_address = a;
      cpu_read = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         #1;
         if (!cpu_waitrequest) begin
            done = 1'b1;
            d = cpu_readdata;
         end else begin
            waits++;
         end
         tick();
      end
      cpu_read = 1'b0;
      chk("cpu_rd_done", {31'd0, done}, 32'd1);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] rnd;
      int          w;
      int          op;
      bit          done;

      for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
      m_ptr = 0; m_ready = 0; m_error = 0; m_go = 0; m_ovr = 0; m_mondreg = 32'h0;
      reset = 1'b1;
      jdo = '0;
      take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
      cpu_address = '0; cpu_read = 0; cpu_write = 0; cpu_writedata = '0;
      tick(); tick();
      chk("rst_mondreg", MonDReg, 32'h0);
      chk("rst_readdata", cpu_readdata, 32'h0);
      chk("rst_wait", {31'd0, cpu_waitrequest}, 32'd0);
      chk_flags("rst");
      reset = 1'b0;
      tick();

      // address load alone changes no output
      dbg_a(0, 0, 1, 8'h10);
      chk("lda_mondreg", MonDReg, 32'h0);
      chk_flags("lda");

      // write, reload, read back; pointer ends at 0x11
      dbg_b(32'hDEAD_BEEF);
      dbg_a(0, 0, 1, 8'h10);
      dbg_rd("rd_deadbeef");
      dbg_b(32'h1111_1111);
      cpu_rd(9'h011, rd, w);
      chk("ptr_after_rd", rd, m_mem[8'h11]);
      chk("cpu_rd_wait1", w, 1);

      // pointer wrap from 0xFF to 0x00
      cpu_wr(9'h000, 32'hA5A5_0001, w);
      chk("cpu_wr_wait0", w, 0);
      dbg_a(0, 0, 1, 8'hFF);
      dbg_b(32'h0BAD_F00D);
      dbg_rd("rd_wrap");
      cpu_rd(9'h0FF, rd, w);
      chk("wrap_ff", rd, 32'h0BAD_F00D);

      // strobe one cycle after a read strobe is dropped
      dbg_a(0, 0, 1, 8'h30);
      cpu_wr(9'h031, 32'h3131_3131, w);
      cpu_wr(9'h030, 32'h3030_3030, w);
      take_no_action_ocimem_a = 1'b1;
      tick();
      take_no_action_ocimem_a = 1'b0;
      jdo = '0;
      jdo[34:3] = 32'hEEEE_EEEE;
      take_action_ocimem_b = 1'b1;
      tick();
      take_action_ocimem_b = 1'b0;
      jdo = '0;
      tick();
      m_ptr = 8'h31; m_ovr = 1'b1;
      chk("ovr_mondreg", MonDReg, 32'h3030_3030);
      m_mondreg = 32'h3030_3030;
      chk("ovr_set", {31'd0, dbg_overrun}, 32'd1);
      cpu_rd(9'h031, rd, w);
      chk("ovr_no_write", rd, 32'h3131_3131);
      dbg_a(0, 0, 0, 0);
      chk("ovr_clear", {31'd0, dbg_overrun}, 32'd0);
      dbg_rd("ovr_ptr");

      // CPU RAM read collides with a debug read strobe
      cpu_wr(9'h055, 32'h5555_AAAA, w);
      cpu_wr(9'h040, 32'h4040_4040, w);
      dbg_a(0, 0, 1, 8'h40);
      cpu_address = 9'h055;
      cpu_read = 1'b1;
      take_no_action_ocimem_a = 1'b1;
      done = 1'b0;
      w = 0;
      rd = '0;
      for (int i = 0; i < 20 && !done; i++) begin
         #1;
         if (!cpu_waitrequest) begin
            done = 1'b1;
            rd = cpu_readdata;
         end else begin
            w++;
         end
         tick();
         take_no_action_ocimem_a = 1'b0;
      end
      cpu_read = 1'b0;
      m_ptr = 8'h41;
      m_mondreg = 32'h4040_4040;
      chk("coll_done", {31'd0, done}, 32'd1);
      chk("coll_waits", w, 3);
      chk("coll_cpu_data", rd, 32'h5555_AAAA);
      chk("coll_mondreg", MonDReg, 32'h4040_4040);

      // monitor flags
      cpu_wr(9'h100, 32'h3, w);
      chk_flags("set_rdy_err");
      jdo = '0;
      jdo[34] = 1'b1;
      take_action_ocimem_a = 1'b1;
      cpu_address = 9'h100;
      cpu_writedata = 32'h3;
      cpu_write = 1'b1;
      tick();
      take_action_ocimem_a = 1'b0;
      cpu_write = 1'b0;
      jdo = '0;
      m_ready = 1'b0; m_error = 1'b0; m_ovr = 1'b0;
      chk_flags("clr_beats_set");
      dbg_a(0, 1, 0, 0);
      chk("go_set", {31'd0, monitor_go}, 32'd1);
      cpu_rd(9'h100, rd, w);
      chk("ctrl_rd_go", rd, 32'h4);
      chk("ctrl_rd_wait0", w, 0);
      cpu_wr(9'h100, 32'h4, w);
      cpu_rd(9'h100, rd, w);
      chk("ctrl_rd_zero", rd, 32'h0);
      jdo = '0;
      jdo[25] = 1'b1;
      take_action_ocimem_a = 1'b1;
      cpu_address = 9'h100;
      cpu_writedata = 32'h4;
      cpu_write = 1'b1;
      tick();
      take_action_ocimem_a = 1'b0;
      cpu_write = 1'b0;
      jdo = '0;
      chk("go_clear_beats_set", {31'd0, monitor_go}, 32'd0);

      // two strobes together: write taken, read dropped, overrun set
      dbg_a(0, 0, 1, 8'h60);
      jdo = '0;
      jdo[34:3] = 32'h6060_6060;
      take_action_ocimem_b = 1'b1;
      take_no_action_ocimem_a = 1'b1;
      tick();
      take_action_ocimem_b = 1'b0;
      take_no_action_ocimem_a = 1'b0;
      jdo = '0;
      m_mem[8'h60] = 32'h6060_6060;
      m_ptr = 8'h61;
      m_ovr = 1'b1;
      tick(); tick();
      chk("multi_ovr", {31'd0, dbg_overrun}, 32'd1);
      chk("multi_no_read", MonDReg, m_mondreg);
      cpu_rd(9'h060, rd, w);
      chk("multi_write", rd, 32'h6060_6060);

      // reset while a debug read is in flight
      cpu_wr(9'h100, 32'h1, w);
      dbg_a(0, 1, 1, 8'h20);
      take_no_action_ocimem_a = 1'b1;
      tick();
      take_no_action_ocimem_a = 1'b0;
      reset = 1'b1;
      #1;
      m_ready = 0; m_error = 0; m_go = 0; m_ovr = 0; m_mondreg = 32'h0; m_ptr = 0;
      chk("midrst_mondreg", MonDReg, 32'h0);
      chk_flags("midrst");
      tick();
      reset = 1'b0;
      tick();
      cpu_rd(9'h020, rd, w);
      chk("midrst_ram_kept", rd, m_mem[8'h20]);
      dbg_rd("midrst_ptr0");

      // randomized traffic against the model
      for (int it = 0; it < 80; it++) begin
         op = $urandom_range(0, 5);
         rnd = $urandom;
         case (op)
            0: dbg_a(0, 0, 1, $urandom_range(0, 255));
            1: dbg_b(rnd);
            2: dbg_rd("rnd_dbg_rd");
            3: begin
               cpu_wr({1'b0, rnd[7:0]}, $urandom, w);
               chk("rnd_wr_wait", w, 0);
            end
            4: begin
               cpu_rd({1'b0, rnd[7:0]}, rd, w);
               chk("rnd_cpu_rd", rd, m_mem[rnd[7:0]]);
               chk("rnd_rd_wait", w, 1);
            end
            default: begin
               cpu_wr(9'h100, {29'd0, rnd[2:0]}, w);
               cpu_rd(9'h100, rd, w);
               chk("rnd_ctrl", rd, {29'd0, m_go, m_error, m_ready});
            end
         endcase
      end
      chk_flags("rnd_end");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
